// File: rtl/ch4x16bit_to_rgb48bit_ctrl_if.sv
// Bundle between the lane/sync FIFOs, the unpacker and the downstream
// timing generator. The unpacker uses the master view; the environment
// that owns the FIFOs and consumes the pixel stream uses the slave view.
interface ch4x16bit_to_rgb48bit_ctrl_if;
    // FWFT head words of the four lane FIFOs and their flags
    logic [15:0] lane_data [4];
    logic [3:0]  lane_empty;
    logic [3:0]  lane_rden;
    // FWFT head code of the sync FIFO
    logic [7:0]  ctrl_data;
    logic        ctrl_empty;
    logic        ctrl_rden;
    // Rebuilt pixel-pair stream with regenerated sync pulses
    logic [23:0] rxo_rgb;
    logic [23:0] rxe_rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic [7:0]  err_cnt;

    modport master (
        input  lane_data, lane_empty, ctrl_data, ctrl_empty,
        output lane_rden, ctrl_rden, rxo_rgb, rxe_rgb, de, hs, vs, err_cnt
    );

    modport slave (
        output lane_data, lane_empty, ctrl_data, ctrl_empty,
        input  lane_rden, ctrl_rden, rxo_rgb, rxe_rgb, de, hs, vs, err_cnt
    );
endinterface

// File: rtl/ch4x16bit_to_rgb48bit_ctrl.sv
// Receive-side unpacker: rebuilds the dual-pixel 48-bit RGB stream from four
// 16-bit lane FIFOs (show-ahead) plus the 8-bit sync-code FIFO, regenerating
// one-cycle hsync/vsync pulses from the sync codes.
//
// Line byte n travels on lane n mod 4; each lane word carries the earlier
// byte in [7:0] and the later one in [15:8]. Four pixel pairs (24 bytes)
// consume three words per lane, so a 2-bit phase selects which lanes are
// popped and which high bytes must be kept for the next pair.
module ch4x16bit_to_rgb48bit_ctrl #(
    parameter int         H_PAIRS     = 960,
    parameter logic [7:0] DVS_VALID   = 8'hF0,
    parameter logic [7:0] DES_INVALID = 8'h0F,
    parameter logic [7:0] DES_VALID   = 8'hFF
) (
    input  logic                          I_sclk,
    input  logic                          I_rst_n,
    ch4x16bit_to_rgb48bit_ctrl_if.master  bus
);

    localparam logic [11:0] LAST_PAIR = 12'(H_PAIRS - 1);

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } state_t;

    state_t      state;
    logic [1:0]  ph;
    logic [11:0] pair_cnt;
    logic [7:0]  held [4];

    logic [7:0]  lo [4];
    logic [7:0]  hi [4];
    logic [3:0]  need;
    logic        lanes_ready;
    logic        pair_pop;
    logic        code_pop;
    logic [23:0] odd_pix;
    logic [23:0] even_pix;

    // Split each lane head word into its earlier (lo) and later (hi) byte
    always_comb begin
        lo[0] = bus.lane_data[0][7:0];
        lo[1] = bus.lane_data[1][7:0];
        lo[2] = bus.lane_data[2][7:0];
        lo[3] = bus.lane_data[3][7:0];
        hi[0] = bus.lane_data[0][15:8];
        hi[1] = bus.lane_data[1][15:8];
        hi[2] = bus.lane_data[2][15:8];
        hi[3] = bus.lane_data[3][15:8];
    end

    // Lanes that must be popped in the current phase
    always_comb begin
        need = 4'b1111;
        case (ph)
            2'd0:    need = 4'b1111;
            2'd1:    need = 4'b1111;
            2'd2:    need = 4'b0011;
            2'd3:    need = 4'b1100;
            default: need = 4'b1111;
        endcase
    end

    // Pop decisions: a pair moves only when every required lane has data,
    // and the sync FIFO is drained only while waiting for a line
    always_comb begin
        lanes_ready   = ((need & bus.lane_empty) == 4'b0000);
        pair_pop      = I_rst_n && (state == ACTIVE) && lanes_ready;
        code_pop      = I_rst_n && (state == IDLE) && !bus.ctrl_empty;
        bus.lane_rden = pair_pop ? need : '0;
        bus.ctrl_rden = code_pop;
    end

    // Assemble the pair for the current phase from fresh and held bytes
    always_comb begin
        odd_pix  = '0;
        even_pix = '0;
        case (ph)
            2'd0: begin
                odd_pix  = {lo[0], lo[1], lo[2]};
                even_pix = {lo[3], hi[0], hi[1]};
            end
            2'd1: begin
                odd_pix  = {held[2], held[3], lo[0]};
                even_pix = {lo[1], lo[2], lo[3]};
            end
            2'd2: begin
                odd_pix  = {held[0], held[1], held[2]};
                even_pix = {held[3], lo[0], lo[1]};
            end
            2'd3: begin
                odd_pix  = {lo[2], lo[3], held[0]};
                even_pix = {held[1], hi[2], hi[3]};
            end
            default: begin
                odd_pix  = '0;
                even_pix = '0;
            end
        endcase
    end

    // Control FSM with registered stream outputs and sync pulses
    always_ff @(posedge I_sclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= IDLE;
            ph          <= '0;
            pair_cnt    <= '0;
            held[0]     <= '0;
            held[1]     <= '0;
            held[2]     <= '0;
            held[3]     <= '0;
            bus.rxo_rgb <= '0;
            bus.rxe_rgb <= '0;
            bus.de      <= 1'b0;
            bus.hs      <= 1'b0;
            bus.vs      <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            bus.de <= 1'b0;
            bus.hs <= 1'b0;
            bus.vs <= 1'b0;

            case (state)
                IDLE: begin
                    if (code_pop) begin
                        case (bus.ctrl_data)
                            DVS_VALID:   bus.vs <= 1'b1;
                            DES_INVALID: bus.hs <= 1'b1;
                            DES_VALID: begin
                                state    <= ACTIVE;
                                ph       <= '0;
                                pair_cnt <= '0;
                            end
                            default: begin
                                if (bus.err_cnt != 8'hFF) begin
                                    bus.err_cnt <= bus.err_cnt + 8'd1;
                                end
                            end
                        endcase
                    end
                end

                ACTIVE: begin
                    if (pair_pop) begin
                        bus.rxo_rgb <= odd_pix;
                        bus.rxe_rgb <= even_pix;
                        bus.de      <= 1'b1;

                        // Keep the high bytes that belong to the next pair
                        case (ph)
                            2'd0: begin
                                held[2] <= hi[2];
                                held[3] <= hi[3];
                            end
                            2'd1: begin
                                held[0] <= hi[0];
                                held[1] <= hi[1];
                                held[2] <= hi[2];
                                held[3] <= hi[3];
                            end
                            2'd2: begin
                                held[0] <= hi[0];
                                held[1] <= hi[1];
                            end
                            default: begin
                            end
                        endcase

                        if (pair_cnt == LAST_PAIR) begin
                            state    <= IDLE;
                            ph       <= '0;
                            pair_cnt <= '0;
                        end else begin
                            ph       <= ph + 2'd1;
                            pair_cnt <= pair_cnt + 12'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ch4x16bit_to_rgb48bit_ctrl.sv
// Directed bench for the lane unpacker: FIFO models with FWFT behaviour feed
// the DUT, a negedge monitor logs every output pair and sync pulse, and the
// expected pairs are derived directly from the line byte numbering.
module tb_ch4x16bit_to_rgb48bit_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    ch4x16bit_to_rgb48bit_ctrl_if bus ();

    ch4x16bit_to_rgb48bit_ctrl #(
        .H_PAIRS     (8),
        .DVS_VALID   (8'hF0),
        .DES_INVALID (8'h0F),
        .DES_VALID   (8'hFF)
    ) dut (
        .I_sclk  (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    // FIFO models
    logic [15:0] lmem [4][256];
    int          lwr [4] = '{default: 0};
    int          lrd [4] = '{default: 0};
    int          pops [4] = '{default: 0};
    logic [7:0]  cmem [512];
    int          cwr = 0;
    int          crd = 0;
    int          underflow = 0;

    assign bus.lane_data[0] = lmem[0][lrd[0][7:0]];
    assign bus.lane_data[1] = lmem[1][lrd[1][7:0]];
    assign bus.lane_data[2] = lmem[2][lrd[2][7:0]];
    assign bus.lane_data[3] = lmem[3][lrd[3][7:0]];
    assign bus.lane_empty   = {lrd[3] == lwr[3], lrd[2] == lwr[2],
                               lrd[1] == lwr[1], lrd[0] == lwr[0]};
    assign bus.ctrl_data    = cmem[crd[8:0]];
    assign bus.ctrl_empty   = (crd == cwr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (bus.lane_rden[k[1:0]]) begin
                lrd[k[1:0]]  <= lrd[k[1:0]] + 1;
                pops[k[1:0]] <= pops[k[1:0]] + 1;
                if (bus.lane_empty[k[1:0]]) underflow <= underflow + 1;
            end
        end
        if (bus.ctrl_rden) begin
            crd <= crd + 1;
            if (bus.ctrl_empty) underflow <= underflow + 1;
        end
    end

    // Output monitor
    logic [23:0] po [64];
    logic [23:0] pe [64];
    int          dcyc [64];
    int          hcyc [16];
    int          dn = 0;
    int          hn = 0;
    int          vn = 0;

    always @(negedge clk) begin
        if (bus.de) begin
            po[dn[5:0]]   <= bus.rxo_rgb;
            pe[dn[5:0]]   <= bus.rxe_rgb;
            dcyc[dn[5:0]] <= cyc;
            dn            <= dn + 1;
        end
        if (bus.hs) begin
            hcyc[hn[3:0]] <= cyc;
            hn            <= hn + 1;
        end
        if (bus.vs) vn <= vn + 1;
    end

    function automatic int get_dcyc(input int i);
        return dcyc[i[5:0]];
    endfunction

    function automatic int get_hcyc(input int i);
        return hcyc[i[3:0]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_lane(input logic [1:0] k, input logic [15:0] word);
        lmem[k][lwr[k][7:0]] = word;
        lwr[k] = lwr[k] + 1;
    endtask

    task automatic push_code(input logic [7:0] code);
        cmem[cwr[8:0]] = code;
        cwr = cwr + 1;
    endtask

    // Lane 3 receives only its first lane3_words words
    task automatic push_line(input logic [7:0] base, input int lane3_words);
        logic [7:0] b_lo;
        logic [7:0] b_hi;
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < 4; k++) begin
                b_lo = base + 8'(8 * w + k);
                b_hi = base + 8'(8 * w + k + 4);
                if (k != 3 || w < lane3_words) push_lane(k[1:0], {b_hi, b_lo});
            end
        end
    endtask

    task automatic check_line(input int start, input logic [7:0] base, input string name);
        logic [7:0]  b [6];
        logic [23:0] got_o;
        logic [23:0] got_e;
        int          idx;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < 6; j++) b[j] = base + 8'(6 * p + j);
            idx   = start + p;
            got_o = po[idx[5:0]];
            got_e = pe[idx[5:0]];
            chk($sformatf("%s pair%0d odd", name, p), {8'h00, got_o}, {8'h00, b[0], b[1], b[2]});
            chk($sformatf("%s pair%0d even", name, p), {8'h00, got_e}, {8'h00, b[3], b[4], b[5]});
        end
    endtask

    task automatic wait_pairs(input int target, input int budget, input string name);
        int n = 0;
        while (dn < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, " pairs arrived"}, 32'(dn >= target), 32'd1);
    endtask

    task automatic flush_all();
        for (int k = 0; k < 4; k++) lwr[k[1:0]] = lrd[k[1:0]];
        cwr = crd;
    endtask

    typedef struct {
        logic [7:0] code;
        logic       hs;
        logic       vs;
        logic [7:0] err;
    } code_vec_t;

    code_vec_t vecs [4];

    initial begin
        int d0;
        int h0;
        int n;
        int p0 [4];
        int s0 [4];

        vecs[0] = '{code: 8'hF0, hs: 1'b0, vs: 1'b1, err: 8'd0};
        vecs[1] = '{code: 8'h55, hs: 1'b0, vs: 1'b0, err: 8'd1};
        vecs[2] = '{code: 8'h0F, hs: 1'b1, vs: 1'b0, err: 8'd1};
        vecs[3] = '{code: 8'hA0, hs: 1'b0, vs: 1'b0, err: 8'd2};

        // Reset with every FIFO holding data
        push_line(8'h00, 6);
        push_code(8'h0F);
        repeat (3) @(negedge clk);
        chk("rst rxo", {8'h00, bus.rxo_rgb}, 32'd0);
        chk("rst rxe", {8'h00, bus.rxe_rgb}, 32'd0);
        chk("rst de/hs/vs", {29'd0, bus.de, bus.hs, bus.vs}, 32'd0);
        chk("rst err", {24'd0, bus.err_cnt}, 32'd0);
        chk("rst rden", {27'd0, bus.lane_rden, bus.ctrl_rden}, 32'd0);
        flush_all();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle outputs", {bus.rxo_rgb, 5'd0, bus.de, bus.hs, bus.vs}, 32'd0);
        chk("idle no pops", 32'(pops[0] + pops[1] + pops[2] + pops[3] + crd), 32'd0);

        // Back-to-back codes, one table row per cycle
        for (int i = 0; i < 4; i++) push_code(vecs[i].code);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("code%0d hs", i), {31'd0, bus.hs}, {31'd0, vecs[i].hs});
            chk($sformatf("code%0d vs", i), {31'd0, bus.vs}, {31'd0, vecs[i].vs});
            chk($sformatf("code%0d err", i), {24'd0, bus.err_cnt}, {24'd0, vecs[i].err});
        end
        @(negedge clk);
        chk("codes pulses end", {30'd0, bus.hs, bus.vs}, 32'd0);

        // Saturation of the unknown-code counter
        for (int i = 0; i < 300; i++) push_code(8'h12);
        n = 0;
        while (crd != cwr && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("err saturates", {24'd0, bus.err_cnt}, 32'd255);

        // Plain active line
        d0 = dn;
        h0 = hn;
        for (int k = 0; k < 4; k++) p0[k] = pops[k];
        push_line(8'h00, 6);
        push_code(8'h0F);
        push_code(8'hFF);
        wait_pairs(d0 + 8, 100, "line1");
        repeat (2) @(negedge clk);
        chk("line1 hs count", 32'(hn - h0), 32'd1);
        chk("line1 de contiguous", 32'(get_dcyc(d0 + 7) - get_dcyc(d0)), 32'd7);
        chk("line1 hs to de", 32'(get_dcyc(d0) - get_hcyc(h0)), 32'd2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("line1 lane%0d pops", k), 32'(pops[k] - p0[k]), 32'd6);
        check_line(d0, 8'h00, "line1");
        chk("data hold", {bus.rxo_rgb, 7'd0, bus.de}, {24'h2A2B2C, 8'h00});

        // Lane 3 starved at phase 1 for three cycles
        d0 = dn;
        push_line(8'h00, 1);
        push_code(8'h0F);
        push_code(8'hFF);
        n = 0;
        while (!bus.de && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall first pair", {31'd0, bus.de}, 32'd1);
        for (int k = 0; k < 4; k++) s0[k] = pops[k];
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk($sformatf("stall gap%0d", g), {31'd0, bus.de}, 32'd0);
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("stall lane%0d no pop", k), 32'(pops[k] - s0[k]), 32'd0);
        for (int w = 1; w < 6; w++)
            push_lane(2'd3, {8'(8 * w + 7), 8'(8 * w + 3)});
        wait_pairs(d0 + 8, 100, "stall");
        check_line(d0, 8'h00, "stall");
        chk("stall span", 32'(get_dcyc(d0 + 7) - get_dcyc(d0)), 32'd10);

        // Reset in the middle of a line
        push_line(8'h40, 6);
        push_code(8'hFF);
        n = 0;
        begin
            int seen = 0;
            while (seen < 4 && n < 60) begin
                @(negedge clk);
                if (bus.de) seen++;
                n++;
            end
            chk("midline pairs seen", 32'(seen), 32'd4);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst data", {bus.rxo_rgb, 8'd0} | {8'd0, bus.rxe_rgb}, 32'd0);
        chk("midrst flags", {27'd0, bus.de, bus.hs, bus.vs, bus.ctrl_rden, |bus.lane_rden}, 32'd0);
        flush_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst err cleared", {24'd0, bus.err_cnt}, 32'd0);
        d0 = dn;
        push_line(8'h80, 6);
        push_code(8'hFF);
        wait_pairs(d0 + 8, 100, "fresh");
        check_line(d0, 8'h80, "fresh");

        // Two lines back to back
        d0 = dn;
        h0 = hn;
        push_line(8'h00, 6);
        push_line(8'h30, 6);
        push_code(8'h0F);
        push_code(8'hFF);
        push_code(8'h0F);
        push_code(8'hFF);
        wait_pairs(d0 + 16, 200, "b2b");
        repeat (2) @(negedge clk);
        chk("b2b hs count", 32'(hn - h0), 32'd2);
        chk("b2b second hs", 32'(get_hcyc(h0 + 1) - get_dcyc(d0 + 7)), 32'd1);
        chk("b2b line gap", 32'(get_dcyc(d0 + 8) - get_dcyc(d0 + 7)), 32'd3);
        check_line(d0, 8'h00, "b2b line1");
        check_line(d0 + 8, 8'h30, "b2b line2");

        chk("no fifo underflow", 32'(underflow), 32'd0);
        chk("vs count", 32'(vn), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
